// File: rtl/image_pipe_pkg.sv
// image_pipe shared types: pattern modes, source FSM states, LFSR helper.
// Imported by the source top and its LFSR sub-module.
package image_pipe_pkg;

  typedef enum logic [1:0] {
    PM_INCR  = 2'd0,
    PM_CONST = 2'd1,
    PM_LFSR  = 2'd2,
    PM_XY    = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_END  = 2'd2,
    ST_DONE = 2'd3
  } src_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Right-shifting Galois step; taps folded in when bit 0 falls out.
  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/image_pipe_lfsr.sv
// 32-bit Galois LFSR with seed load and per-beat advance.
// value shows the loaded seed combinationally so a beat can use it on the load edge.
module image_pipe_lfsr
  import image_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        s_rst_n,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  logic [31:0] st_q;
  logic [31:0] seed_fix;

  assign seed_fix = (seed == 32'h0) ? 32'd1 : seed;
  assign value    = load ? seed_fix : st_q;

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      st_q <= 32'd1;
    end else if (adv) begin
      st_q <= lfsr_step(value);
    end else if (load) begin
      st_q <= value;
    end
  end

endmodule

// File: rtl/image_pipe_src.sv
// image_pipe frame source: W x H pattern beats with busy backpressure,
// a held end marker, abort, and a one-cycle frame_done pulse.
module image_pipe_src
  import image_pipe_pkg::*;
#(
  parameter int DW_OUT = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_height,
  input  logic [1:0]        cfg_mode,
  input  logic [31:0]       cfg_seed,
  output logic [DW_OUT-1:0] image_pipe_data_out,
  output logic              image_pipe_valid_out,
  output logic              image_pipe_end_out,
  input  logic              image_pipe_busy_in,
  output logic              src_active,
  output logic              frame_done,
  output logic [31:0]       beat_cnt
);

  src_state_e st, st_nx;

  logic [CNT_W-1:0] x_q, y_q, w_q, h_q;
  logic [CNT_W-1:0] x_nx, y_nx, w_nx, h_nx;
  pat_mode_e        mode_q, mode_nx;
  logic [31:0]      seed_q, seed_nx;

  logic [31:0]       cnt_nx;
  logic [DW_OUT-1:0] data_nx;
  logic              valid_nx;
  logic              end_nx;
  logic              done_nx;
  logic              act_nx;

  logic        lfsr_load;
  logic        lfsr_adv;
  logic [31:0] lfsr_val;

  logic             idle;
  logic             issue;
  logic             last;
  logic             x_wrap;
  pat_mode_e        p_mode;
  logic [31:0]      p_seed;
  logic [31:0]      p_n;
  logic [CNT_W-1:0] p_x, p_y, p_w, p_h;
  logic [31:0]      px32, py32;
  logic [31:0]      pix;

  function automatic logic [CNT_W-1:0] fix0(
    input logic [CNT_W-1:0] v
  );
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  image_pipe_lfsr u_lfsr (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .load    (lfsr_load),
    .adv     (lfsr_adv),
    .seed    (p_seed),
    .value   (lfsr_val)
  );

  // In IDLE the start-edge beat is built from live cfg, else from shadows.
  assign idle   = (st == ST_IDLE);
  assign p_mode = idle ? pat_mode_e'(cfg_mode) : mode_q;
  assign p_seed = idle ? cfg_seed : seed_q;
  assign p_w    = idle ? fix0(cfg_width) : w_q;
  assign p_h    = idle ? fix0(cfg_height) : h_q;
  assign p_x    = idle ? '0 : x_q;
  assign p_y    = idle ? '0 : y_q;
  assign p_n    = idle ? 32'h0 : beat_cnt;

  assign x_wrap = (p_x == p_w - CNT_W'(1));
  assign last   = x_wrap && (p_y == p_h - CNT_W'(1));
  assign px32   = 32'(p_x);
  assign py32   = 32'(p_y);

  always_comb begin
    pix = p_seed;
    unique case (p_mode)
      PM_INCR:  pix = p_seed + p_n;
      PM_CONST: pix = p_seed;
      PM_LFSR:  pix = lfsr_val;
      PM_XY:    pix = {py32[15:0], px32[15:0]};
    endcase
  end

  always_comb begin
    st_nx     = st;
    x_nx      = x_q;
    y_nx      = y_q;
    w_nx      = w_q;
    h_nx      = h_q;
    mode_nx   = mode_q;
    seed_nx   = seed_q;
    cnt_nx    = beat_cnt;
    data_nx   = '0;
    valid_nx  = 1'b0;
    end_nx    = 1'b0;
    done_nx   = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    issue     = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (start) begin
          st_nx     = ST_RUN;
          w_nx      = p_w;
          h_nx      = p_h;
          mode_nx   = p_mode;
          seed_nx   = p_seed;
          x_nx      = '0;
          y_nx      = '0;
          cnt_nx    = 32'h0;
          lfsr_load = 1'b1;
          issue     = !image_pipe_busy_in;
        end
      end
      ST_RUN: begin
        if (abort) st_nx = ST_END;
        else       issue = !image_pipe_busy_in;
      end
      ST_END: begin
        if (image_pipe_end_out &&
            !image_pipe_busy_in) begin
          st_nx   = ST_DONE;
          done_nx = 1'b1;
        end else begin
          end_nx = 1'b1;
        end
      end
      ST_DONE: st_nx = ST_IDLE;
    endcase
    if (issue) begin
      data_nx  = DW_OUT'(pix);
      valid_nx = 1'b1;
      cnt_nx   = p_n + 32'd1;
      lfsr_adv = 1'b1;
      if (x_wrap) begin
        x_nx = '0;
        y_nx = p_y + CNT_W'(1);
      end else begin
        x_nx = p_x + CNT_W'(1);
      end
      if (last) st_nx = ST_END;
    end
    act_nx = (st_nx == ST_RUN) ||
             (st_nx == ST_END);
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      st                   <= ST_IDLE;
      x_q                  <= '0;
      y_q                  <= '0;
      w_q                  <= '0;
      h_q                  <= '0;
      mode_q               <= PM_INCR;
      seed_q               <= 32'h0;
      beat_cnt             <= 32'h0;
      image_pipe_data_out  <= '0;
      image_pipe_valid_out <= 1'b0;
      image_pipe_end_out   <= 1'b0;
      frame_done           <= 1'b0;
      src_active           <= 1'b0;
    end else begin
      st                   <= st_nx;
      x_q                  <= x_nx;
      y_q                  <= y_nx;
      w_q                  <= w_nx;
      h_q                  <= h_nx;
      mode_q               <= mode_nx;
      seed_q               <= seed_nx;
      beat_cnt             <= cnt_nx;
      image_pipe_data_out  <= data_nx;
      image_pipe_valid_out <= valid_nx;
      image_pipe_end_out   <= end_nx;
      frame_done           <= done_nx;
      src_active           <= act_nx;
    end
  end

endmodule
